// File: rtl/morse_tx_if.sv
// Character/keying bus between a Morse transmitter and its host.
// The host drives characters in; the transmitter reports keying and status back.
interface morse_tx_if;
   logic       char_valid;
   logic [4:0] char_in;
   logic       char_ready;
   logic       key_out;
   logic       char_done;
   logic       err;

   modport master (
      output char_valid, char_in,
      input  char_ready, key_out, char_done, err
   );

   modport slave (
      input  char_valid, char_in,
      output char_ready, key_out, char_done, err
   );
endinterface

// File: rtl/morse_tx.sv
// International Morse keyer for A-Z plus word space.
// Timing is counted in units of UNIT_CYCLES clocks.
module morse_tx #(
   parameter int UNIT_CYCLES = 4
) (
   input  logic     clk,
   input  logic     rst,
   morse_tx_if.slave bus
);

   localparam int CW = $clog2(4 * UNIT_CYCLES);
   localparam logic [CW-1:0] DOT_N  = CW'(UNIT_CYCLES - 1);
   localparam logic [CW-1:0] DASH_N = CW'(3 * UNIT_CYCLES - 1);
   localparam logic [CW-1:0] WORD_N = CW'(4 * UNIT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, MARK, GAP, CHAR_GAP, WORD_GAP} state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [1:0]    r_idx;
   logic [3:0]    r_pat;
   logic          r_key;
   logic          r_done;
   logic          r_err;

   logic [5:0]    w_ent;
   logic [3:0]    w_pat;
   logic [1:0]    w_len_m1;
   logic          w_accept;

   // Entry is {length-1, pattern}; pattern bit 1 = dash, sent MSB-first.
   function automatic logic [5:0] morse_lut(input logic [4:0] c);
      case (c)
         5'd0:    morse_lut = {2'd1, 4'b0001}; // A .-
         5'd1:    morse_lut = {2'd3, 4'b1000}; // B -...
         5'd2:    morse_lut = {2'd3, 4'b1010}; // C -.-.
         5'd3:    morse_lut = {2'd2, 4'b0100}; // D -..
         5'd4:    morse_lut = {2'd0, 4'b0000}; // E .
         5'd5:    morse_lut = {2'd3, 4'b0010}; // F ..-.
         5'd6:    morse_lut = {2'd2, 4'b0110}; // G --.
         5'd7:    morse_lut = {2'd3, 4'b0000}; // H ....
         5'd8:    morse_lut = {2'd1, 4'b0000}; // I ..
         5'd9:    morse_lut = {2'd3, 4'b0111}; // J .---
         5'd10:   morse_lut = {2'd2, 4'b0101}; // K -.-
         5'd11:   morse_lut = {2'd3, 4'b0100}; // L .-..
         5'd12:   morse_lut = {2'd1, 4'b0011}; // M --
         5'd13:   morse_lut = {2'd1, 4'b0010}; // N -.
         5'd14:   morse_lut = {2'd2, 4'b0111}; // O ---
         5'd15:   morse_lut = {2'd3, 4'b0110}; // P .--.
         5'd16:   morse_lut = {2'd3, 4'b1101}; // Q --.-
         5'd17:   morse_lut = {2'd2, 4'b0010}; // R .-.
         5'd18:   morse_lut = {2'd2, 4'b0000}; // S ...
         5'd19:   morse_lut = {2'd0, 4'b0001}; // T -
         5'd20:   morse_lut = {2'd2, 4'b0001}; // U ..-
         5'd21:   morse_lut = {2'd3, 4'b0001}; // V ...-
         5'd22:   morse_lut = {2'd2, 4'b0011}; // W .--
         5'd23:   morse_lut = {2'd3, 4'b1001}; // X -..-
         5'd24:   morse_lut = {2'd3, 4'b1011}; // Y -.--
         5'd25:   morse_lut = {2'd3, 4'b1100}; // Z --..
         default: morse_lut = 6'd0;
      endcase
   endfunction

   assign w_ent    = morse_lut(bus.char_in);
   assign w_pat    = w_ent[3:0];
   assign w_len_m1 = w_ent[5:4];

   assign bus.char_ready = (r_state == IDLE) && !rst;
   assign w_accept       = bus.char_valid && bus.char_ready;

   assign bus.key_out   = r_key;
   assign bus.char_done = r_done;
   assign bus.err       = r_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_pat   <= '0;
         r_key   <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  if (bus.char_in < 5'd26) begin
                     r_state <= MARK;
                     r_key   <= 1'b1;
                     r_idx   <= w_len_m1;
                     r_pat   <= w_pat;
                     r_cnt   <= w_pat[w_len_m1] ? DASH_N : DOT_N;
                  end else if (bus.char_in == 5'd26) begin
                     r_state <= WORD_GAP;
                     r_cnt   <= WORD_N;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            MARK: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CW'(1);
               end else begin
                  r_key <= 1'b0;
                  if (r_idx == 2'd0) begin
                     r_state <= CHAR_GAP;
                     r_cnt   <= DASH_N;
                  end else begin
                     r_state <= GAP;
                     r_cnt   <= DOT_N;
                     r_idx   <= r_idx - 2'd1;
                  end
               end
            end
            GAP: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CW'(1);
               end else begin
                  // r_idx already points at the next element
                  r_state <= MARK;
                  r_key   <= 1'b1;
                  r_cnt   <= r_pat[r_idx] ? DASH_N : DOT_N;
               end
            end
            CHAR_GAP, WORD_GAP: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CW'(1);
               end else begin
                  r_state <= IDLE;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_morse_tx.sv
// Scoreboard bench for morse_tx: a dot/dash string model queues per-cycle
// expectations at each acceptance, and a negedge monitor compares them.
module tb_morse_tx;
   localparam int U = 4;

   typedef struct packed {
      logic key;
      logic done;
      logic err;
      logic ready;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic mon_en = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t q[$];

   string MORSE [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                         "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                         "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                         "-.--", "--.."};

   always #5 clk = ~clk;

   morse_tx_if bus();

   morse_tx #(.UNIT_CYCLES(U)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic push_run(input int n, input logic k, input logic r);
      for (int i = 0; i < n; i++) q.push_back('{key: k, done: 1'b0, err: 1'b0, ready: r});
   endtask

   // Expected behaviour for cycles 1..N after an accepting edge.
   task automatic model(input logic [4:0] c);
      string s;
      if (c < 26) begin
         s = MORSE[c];
         for (int i = 0; i < s.len(); i++) begin
            push_run((s[i] == "-") ? 3 * U : U, 1'b1, 1'b0);
            if (i < s.len() - 1) push_run(U, 1'b0, 1'b0);
         end
         push_run(3 * U, 1'b0, 1'b0);
         q.push_back('{key: 1'b0, done: 1'b1, err: 1'b0, ready: 1'b1});
      end else if (c == 26) begin
         push_run(4 * U, 1'b0, 1'b0);
         q.push_back('{key: 1'b0, done: 1'b1, err: 1'b0, ready: 1'b1});
      end else begin
         q.push_back('{key: 1'b0, done: 1'b0, err: 1'b1, ready: 1'b1});
      end
   endtask

   task automatic send(input logic [4:0] c, input bit hold);
      int n = 0;
      @(negedge clk);
      while (!bus.char_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!bus.char_ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL ready_timeout code=%0d: char_ready got 0 want 1", c);
         return;
      end
      bus.char_valid = 1'b1;
      bus.char_in    = c;
      @(posedge clk);
      model(c);
      if (!hold) begin
         #1 bus.char_valid = 1'b0;
      end
   endtask

   task automatic check_now(input string name, input logic act, input logic want);
      n_tests++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %b want %b", name, act, want);
      end
   endtask

   // Monitor: one comparison of all outputs per cycle; idle expected when queue empty.
   initial begin
      exp_t e;
      exp_t act;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (q.size() > 0) e = q.pop_front();
            else e = '{key: 1'b0, done: 1'b0, err: 1'b0, ready: ~rst};
            act = '{key: bus.key_out, done: bus.char_done, err: bus.err, ready: bus.char_ready};
            n_tests++;
            if (act !== e) begin
               n_fail++;
               if (n_fail <= 30)
                  $display("FAIL cycle_check t=%0t {key,done,err,ready}: got %b want %b",
                           $time, act, e);
            end
         end
      end
   end

   initial begin
      logic [4:0] code;
      bit         hold;
      int         w;
      bus.char_valid = 1'b0;
      bus.char_in    = 5'd0;
      @(posedge clk);
      mon_en = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Directed: E, A, T then M with valid held, word space, invalid codes
      send(5'd4, 1'b0);
      send(5'd0, 1'b0);
      send(5'd19, 1'b1);
      send(5'd12, 1'b0);
      send(5'd26, 1'b0);
      send(5'd29, 1'b0);
      send(5'd27, 1'b1);
      send(5'd31, 1'b0);

      // Reset in the middle of a T dash
      send(5'd19, 1'b0);
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      q.delete();
      #1;
      check_now("async_key_drop", bus.key_out, 1'b0);
      check_now("ready_in_reset", bus.char_ready, 1'b0);
      bus.char_valid = 1'b1;
      bus.char_in    = 5'd4;
      repeat (3) @(negedge clk);
      check_now("no_done_in_reset", bus.char_done, 1'b0);
      bus.char_valid = 1'b0;
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check_now("ready_after_release", bus.char_ready, 1'b1);
      send(5'd4, 1'b0);

      // Randomized traffic
      for (int i = 0; i < 40; i++) begin
         w = $urandom_range(0, 9);
         if (w < 7)       code = 5'($urandom_range(0, 25));
         else if (w < 8)  code = 5'd26;
         else             code = 5'($urandom_range(27, 31));
         hold = bit'($urandom_range(0, 1));
         send(code, hold);
         if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      #1 bus.char_valid = 1'b0;

      w = 0;
      while (q.size() != 0 && w < 500) begin
         @(negedge clk);
         w++;
      end
      if (q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain_timeout: got %0d pending want 0", q.size());
      end
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
